// File: rtl/punc_mem_arbiter.sv
// Two-port arbiter sharing the PUnC single-port memory between the core (port 0)
// and a host/debug loader (port 1), with a lock for indirect LDI/STI pairs.
module punc_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state, state_nxt;

  logic              owner;      // port of the access in flight
  logic              we_q;
  logic              lock_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              last;       // port granted most recently
  logic              locked;
  logic              lock_owner;

  logic elig0, elig1, any_elig, win;

  // While locked, only the owner's request is visible to arbitration.
  assign elig0    = req0 & (~locked | ~lock_owner);
  assign elig1    = req1 & (~locked |  lock_owner);
  assign any_elig = elig0 | elig1;
  assign win      = (elig0 & elig1) ? ~last : elig1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_q ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      we_q       <= 1'b0;
      lock_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      last       <= 1'b1;
      locked     <= 1'b0;
      lock_owner <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_elig) begin
          owner   <= win;
          we_q    <= win ? we1    : we0;
          lock_q  <= win ? lock1  : lock0;
          addr_q  <= win ? addr1  : addr0;
          wdata_q <= win ? wdata1 : wdata0;
        end
        ISSUE: begin
          last       <= owner;
          locked     <= lock_q;
          lock_owner <= owner;
        end
        RESP: rdata_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  // mem_rdata comes from the memory's own output register, so it is forwarded
  // in RESP and held in rdata_q afterwards.
  always_comb begin
    gnt0      = (state == ISSUE) & ~owner;
    gnt1      = (state == ISSUE) &  owner;
    rvalid0   = (state == RESP)  & ~owner;
    rvalid1   = (state == RESP)  &  owner;
    mem_en    = (state == ISSUE);
    mem_we    = (state == ISSUE) & we_q;
    mem_addr  = (state == ISSUE) ? addr_q  : '0;
    mem_wdata = (state == ISSUE) ? wdata_q : '0;
    rdata     = (state == RESP)  ? mem_rdata : rdata_q;
  end

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Directed and randomized checks of punc_mem_arbiter against a memory model
// and a transaction-level arbitration model.
module tb_punc_mem_arbiter;
  logic        clk = 0;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;
  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];

  int n_chk = 0;
  int n_err = 0;

  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // synchronous-read memory: data appears the cycle after mem_en
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1; pl_addr = a; pl_data = d; ref_mem[a] = d;
    @(negedge clk);
    pl_en = 0;
  endtask

  task automatic do_reset();
    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic set_port(input bit p, input bit rq, input bit we, input bit lk,
                          input logic [15:0] a, input logic [15:0] d);
    if (p) begin req1 = rq; we1 = we; lock1 = lk; addr1 = a; wdata1 = d; end
    else   begin req0 = rq; we0 = we; lock0 = lk; addr0 = a; wdata0 = d; end
  endtask

  // Single access on an idle arbiter; starts and ends at an IDLE-cycle negedge.
  task automatic do_access(input string tag, input bit p, input bit we,
                           input logic [15:0] a, input logic [15:0] d);
    set_port(p, 1, we, 0, a, d);
    @(negedge clk);
    chk({tag, "_gnt"},    p ? gnt1 : gnt0, 1);
    chk({tag, "_ogn"},    p ? gnt0 : gnt1, 0);
    chk({tag, "_en"},     mem_en, 1);
    chk({tag, "_we"},     mem_we, we);
    chk({tag, "_addr"},   mem_addr, a);
    if (we) chk({tag, "_wd"}, mem_wdata, d);
    set_port(p, 0, 0, 0, 0, 0);
    @(negedge clk);
    if (we) begin
      ref_mem[a[7:0]] = d;
      chk({tag, "_norv"}, {rvalid1, rvalid0}, 0);
    end else begin
      chk({tag, "_rv"},    p ? rvalid1 : rvalid0, 1);
      chk({tag, "_orv"},   p ? rvalid0 : rvalid1, 0);
      chk({tag, "_rdata"}, rdata, ref_mem[a[7:0]]);
      @(negedge clk);
      chk({tag, "_hold"},  rdata, ref_mem[a[7:0]]);
      chk({tag, "_rvoff"}, {rvalid1, rvalid0}, 0);
    end
  endtask

  localparam int K = 10;

  initial begin
    bit          o_we0 [0:K], o_we1 [0:K];
    logic [15:0] o_a0 [0:K], o_a1 [0:K], o_d0 [0:K], o_d1 [0:K];
    bit          e_port [0:2*K-1];
    bit          e_we   [0:2*K-1];
    logic [15:0] e_a [0:2*K-1], e_d [0:2*K-1], e_rd [0:2*K-1];
    int i0, i1, g, cyc;
    bit pend, pend_p;
    logic [15:0] pend_v, v40, v50;

    pl_en = 0; pl_addr = 0; pl_data = 0;
    @(negedge clk);
    do_reset();
    chk("rst_outs", {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wd",   mem_wdata, 0);
    chk("rst_rd",   rdata, 0);

    v40 = 16'($urandom); v50 = 16'($urandom);
    preload(8'h10, 16'hBEEF);
    preload(8'h30, 16'h0040);
    preload(8'h40, v40);
    preload(8'h50, v50);

    // basic read and write
    do_access("rd10", 0, 0, 16'h0010, 0);
    do_access("wr20", 1, 1, 16'h0020, 16'h1234);
    do_access("rd20", 0, 0, 16'h0020, 0);

    // continuous requests from both ports alternate, port 0 first
    do_reset();
    set_port(0, 1, 0, 0, 16'h0010, 0);
    set_port(1, 1, 0, 0, 16'h0020, 0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("rr_g0",  gnt0,    (c % 3 == 1) && (((c - 1) / 3) % 2 == 0));
      chk("rr_g1",  gnt1,    (c % 3 == 1) && (((c - 1) / 3) % 2 == 1));
      chk("rr_rv0", rvalid0, (c % 3 == 2) && (((c - 2) / 3) % 2 == 0));
      chk("rr_rv1", rvalid1, (c % 3 == 2) && (((c - 2) / 3) % 2 == 1));
      if (c % 3 == 2) chk("rr_rd", rdata, (((c - 2) / 3) % 2 == 0) ? 16'hBEEF : 16'h1234);
      if (c == 12) begin req0 = 0; req1 = 0; end
    end

    // locked LDI-style pair; port 1 waits until the unlocked access completes,
    // even across a gap where port 0 has no request
    do_reset();
    set_port(0, 1, 0, 1, 16'h0030, 0);
    set_port(1, 1, 0, 0, 16'h0050, 0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("lk_g0",  gnt0,    c == 1 || c == 6);
      chk("lk_g1",  gnt1,    c == 9);
      chk("lk_rv0", rvalid0, c == 2 || c == 7);
      chk("lk_rv1", rvalid1, c == 10);
      if (c == 2)  chk("lk_rd1", rdata, 16'h0040);
      if (c == 7)  chk("lk_rd2", rdata, v40);
      if (c == 10) chk("lk_rd3", rdata, v50);
      if (c == 1) begin req0 = 0; lock0 = 0; end
      if (c == 5) set_port(0, 1, 0, 0, 16'h0040, 0);
      if (c == 6) req0 = 0;
      if (c == 9) req1 = 0;
    end
    @(negedge clk);

    // reset mid-read, after port 0 was the last winner
    do_access("pre", 0, 0, 16'h0010, 0);
    set_port(0, 1, 0, 0, 16'h0010, 0);
    @(negedge clk);
    chk("mr_gnt", gnt0, 1);
    rst = 1; set_port(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mr_outs", {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we}, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_rd",   rdata, 0);
    rst = 0;
    set_port(0, 1, 0, 0, 16'h0010, 0);
    set_port(1, 1, 0, 0, 16'h0050, 0);
    @(negedge clk);
    chk("mr_tie_g0", gnt0, 1);
    chk("mr_tie_g1", gnt1, 0);
    req0 = 0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mr_next_g1", gnt1, 1);
    req1 = 0;
    @(negedge clk); @(negedge clk);

    // reset during a locked access must clear the lock
    set_port(0, 1, 0, 1, 16'h0030, 0);
    @(negedge clk);
    chk("ml_gnt", gnt0, 1);
    rst = 1; set_port(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ml_rv", rvalid0, 0);
    rst = 0;
    do_access("ml_p1", 1, 0, 16'h0050, 0);

    // short req1 pulse during port 0's ISSUE is never served
    set_port(0, 1, 0, 0, 16'h0040, 0);
    @(negedge clk);
    chk("pu_g0", gnt0, 1);
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 1, 1, 0, 16'h0050, 16'hDEAD);
    @(negedge clk);
    chk("pu_rv0", rvalid0, 1);
    chk("pu_rd",  rdata, v40);
    set_port(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("pu_g1", gnt1, 0);
      chk("pu_en", mem_en, 0);
    end

    // randomized: both ports keep a queue of K ops pending; with no lock the
    // grants strictly alternate 0,1,0,1 after reset
    for (int a = 8'h80; a < 8'h90; a++) preload(8'(a), 16'($urandom));
    for (int i = 0; i <= K; i++) begin
      o_we0[i] = 1'($urandom_range(0, 1)); o_we1[i] = 1'($urandom_range(0, 1));
      o_a0[i] = 16'h0080 + 16'($urandom_range(0, 15));
      o_a1[i] = 16'h0080 + 16'($urandom_range(0, 15));
      o_d0[i] = 16'($urandom); o_d1[i] = 16'($urandom);
    end
    for (int i = 0; i < 2 * K; i++) begin
      e_port[i] = 1'(i % 2);
      e_we[i] = e_port[i] ? o_we1[i / 2] : o_we0[i / 2];
      e_a[i]  = e_port[i] ? o_a1[i / 2]  : o_a0[i / 2];
      e_d[i]  = e_port[i] ? o_d1[i / 2]  : o_d0[i / 2];
      e_rd[i] = ref_mem[e_a[i][7:0]];
      if (e_we[i]) ref_mem[e_a[i][7:0]] = e_d[i];
    end
    do_reset();
    i0 = 0; i1 = 0; g = 0; cyc = 0; pend = 0; pend_p = 0; pend_v = 0;
    set_port(0, 1, o_we0[0], 0, o_a0[0], o_d0[0]);
    set_port(1, 1, o_we1[0], 0, o_a1[0], o_d1[0]);
    while ((g < 2 * K || pend) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      chk("rnd_rv0", rvalid0, pend && !pend_p);
      chk("rnd_rv1", rvalid1, pend && pend_p);
      if (pend) chk("rnd_rd", rdata, pend_v);
      pend = 0;
      chk("rnd_en", mem_en, gnt0 | gnt1);
      if (gnt0 | gnt1) begin
        if (g < 2 * K) begin
          chk("rnd_g0",   gnt0, !e_port[g]);
          chk("rnd_g1",   gnt1, e_port[g]);
          chk("rnd_we",   mem_we, e_we[g]);
          chk("rnd_addr", mem_addr, e_a[g]);
          if (e_we[g]) chk("rnd_wd", mem_wdata, e_d[g]);
          else begin pend = 1; pend_p = e_port[g]; pend_v = e_rd[g]; end
        end else chk("rnd_extra_gnt", 1, 0);
        if (gnt0) i0++;
        if (gnt1) i1++;
        g++;
      end
      set_port(0, i0 < K, o_we0[i0 < K ? i0 : K], 0, o_a0[i0 < K ? i0 : K], o_d0[i0 < K ? i0 : K]);
      set_port(1, i1 < K, o_we1[i1 < K ? i1 : K], 0, o_a1[i1 < K ? i1 : K], o_d1[i1 < K ? i1 : K]);
    end
    chk("rnd_done", g, 2 * K);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/punc_mem_arbiter.md
# punc_mem_arbiter

Two-port arbiter that shares the PUnC single-port unified memory between the processor core (port 0: fetch, LD/LDR/LDI, ST/STR/STI) and a host/debug loader (port 1). It sits between the control/datapath memory interface and the memory array. It sequences each access through a small state machine, returns read data with a valid strobe, and supports a lock so the two-access LDI/STI indirection is not interleaved with host traffic.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  access request; held high until the matching gnt pulse
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- lock0 / lock1  in  1  keep ownership for the next access by this port (sampled with gnt)
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: the access is being issued to memory this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds read data for this port
- rdata  out  DATA_W  registered read data, shared by both ports
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: evaluate requests. No req stays in IDLE. Otherwise select the winner, latch its we/addr/wdata/lock into internal registers, and go to ISSUE.
- Winner selection:
  - Only one req high: that port wins.
  - Both high: the port not granted last wins (round-robin pointer `last`).
  - Lock override: if `locked` is set, only the locked owner is eligible. The other port's req is ignored until the lock clears.
- ISSUE: drive mem_en=1, mem_we, mem_addr and mem_wdata from the latched registers. Pulse gnt for the winner and update `last` to the winner.
  - Set `locked` = latched lock, owned by the winner.
  - Write: go to IDLE.
  - Read: go to RESP.
- RESP: capture mem_rdata into rdata, pulse rvalid for the owner, go to IDLE.
- Lock release: a granted access with lock=0 clears `locked`. A port holding the lock that deasserts req does not release it; the lock stays until that port's next unlocked access.
- A req that drops before its gnt is legal. If it drops before IDLE samples it, no access occurs. Once latched, the access completes regardless.
- rdata holds its last value between reads.

## Timing
- Reset values: state=IDLE, last=1 (so port 0 wins the first tie), locked=0; gnt0/1, rvalid0/1, mem_en, mem_we all 0; mem_addr, mem_wdata, rdata all 0.
- All outputs are registered or decoded purely from state plus registers. No req→mem_en combinational path.
- Read latency: req sampled in IDLE at cycle N; gnt and mem_en at N+1; rvalid and rdata at N+2. The next IDLE arbitration is at N+3, so a read occupies 3 cycles.
- Write: gnt and mem_en at N+1; next arbitration at N+2, so a write occupies 2 cycles.
- Back-to-back requests from the same port with no competitor: served every 3 cycles for reads and every 2 cycles for writes.
- Reset mid-access: abandon the access, emit no rvalid, clear the lock. The requester must re-request.
- Simultaneous lock set and competing req: the lock takes effect from the next IDLE evaluation onward.

## Test plan
- Reset, then port 0 reads addr 0x0010 (memory holds 0xBEEF) -> gnt0 at cycle +1 with mem_en=1, mem_we=0, mem_addr=0x0010; rvalid0=1 and rdata=0xBEEF at +2; gnt1 and rvalid1 stay 0.
- Port 1 writes 0x1234 to 0x0020 -> gnt1 and mem_en/mem_we=1 with mem_wdata=0x1234 at +1; no rvalid. A follow-up read of 0x0020 by port 0 returns 0x1234.
- Both ports hold read requests continuously -> grants alternate 0,1,0,1 starting with port 0 after reset. Each grant is followed by an rvalid for the same port.
- Port 0 issues a locked read of 0x0030 (pointer value 0x0040), then an unlocked read of 0x0040, while port 1 holds req throughout -> port 1 is not granted until after port 0's second rvalid.
- Assert rst in the cycle after gnt0 for a read -> no rvalid0, all outputs 0 next cycle, and the next tie is won by port 0.
- Port 1 raises req for one cycle while the arbiter is in ISSUE for port 0, then drops it -> no gnt1 and no memory access for port 1.
